// File: rtl/asp_pkg.sv
// Shared opcode constants and scheduler FSM state type.
package asp_pkg;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_TXE = 2'b01;
   localparam logic [1:0] OP_RXA = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

endpackage

// File: rtl/asp_rr_arb.sv
// Two-requester round-robin arbiter; req[0] is host, req[1] is network.
module asp_rr_arb (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic       enable,
   output logic [1:0] grant
);

   // Set when the host won the most recent grant, so a tie goes to the network next.
   logic last_grant_q;

   always_comb begin
      grant = 2'b00;
      if (enable) begin
         if (req == 2'b11) grant = last_grant_q ? 2'b10 : 2'b01;
         else              grant = req;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     last_grant_q <= 1'b0;
      else if (|grant)  last_grant_q <= grant[0];
   end

endmodule

// File: rtl/asp_op_scheduler.sv
// Single-in-flight operation scheduler: arbitrates host TX / network RX requests,
// issues TXE/RXA opcodes, and tracks retries and timeouts until completion.
import asp_pkg::*;

module asp_op_scheduler #(
   parameter int data_size      = 32,
   parameter int tag_size       = 8,
   parameter int max_retry      = 3,
   parameter int timeout_cycles = 16
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         host_tx_req,
   input  logic [data_size-1:0]         host_tx_data,
   input  logic [tag_size-1:0]          host_tx_tag,
   output logic                         host_tx_grant,
   input  logic                         net_rx_req,
   input  logic [data_size+tag_size-1:0] net_rx_ndt,
   output logic                         net_rx_grant,
   output logic [1:0]                   opcode_out,
   output logic                         op_valid_out,
   output logic [data_size-1:0]         tx_data_out,
   output logic [tag_size-1:0]          tx_tag_out,
   output logic [data_size+tag_size-1:0] ndt_out,
   input  logic                         parity_error_in,
   input  logic                         network_data_ready_in,
   input  logic                         network_ack_in,
   output logic                         host_done_out,
   output logic                         host_fail_out,
   output logic                         net_ack_out,
   output logic                         net_miss_out,
   output logic                         busy_out
);

   localparam int RW = (max_retry < 1) ? 1 : $clog2(max_retry + 1);
   localparam int TW = (timeout_cycles < 2) ? 1 : $clog2(timeout_cycles);
   localparam logic [RW-1:0] RETRY_MAX = RW'(max_retry);
   localparam logic [TW-1:0] TMO_LAST  = TW'(timeout_cycles - 1);

   state_t                        state_q;
   logic                          op_valid_q, is_rx_q;
   logic [1:0]                    opcode_q;
   logic [data_size-1:0]          tx_data_q;
   logic [tag_size-1:0]           tx_tag_q;
   logic [data_size+tag_size-1:0] ndt_q;
   logic [RW-1:0]                 retry_q;
   logic [TW-1:0]                 tmo_q;
   logic                          done_q, fail_q, ack_q, miss_q;
   logic [1:0]                    grant;
   logic                          tmo_hit;

   // Gating with reset_n keeps the combinational grants low while reset is held.
   asp_rr_arb u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     ({net_rx_req, host_tx_req}),
      .enable  ((state_q == ST_IDLE) && reset_n),
      .grant   (grant)
   );

   assign tmo_hit = (tmo_q == TMO_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         op_valid_q <= 1'b0;
         opcode_q   <= OP_NOP;
         is_rx_q    <= 1'b0;
         tx_data_q  <= '0;
         tx_tag_q   <= '0;
         ndt_q      <= '0;
         retry_q    <= '0;
         tmo_q      <= '0;
         done_q     <= 1'b0;
         fail_q     <= 1'b0;
         ack_q      <= 1'b0;
         miss_q     <= 1'b0;
      end else begin
         op_valid_q <= 1'b0;
         opcode_q   <= OP_NOP;
         done_q     <= 1'b0;
         fail_q     <= 1'b0;
         ack_q      <= 1'b0;
         miss_q     <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (|grant) begin
                  is_rx_q <= grant[1];
                  retry_q <= '0;
                  if (grant[0]) begin
                     tx_data_q <= host_tx_data;
                     tx_tag_q  <= host_tx_tag;
                  end else begin
                     ndt_q <= net_rx_ndt;
                  end
                  op_valid_q <= 1'b1;
                  opcode_q   <= grant[1] ? OP_RXA : OP_TXE;
                  state_q    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               tmo_q   <= '0;
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (!tmo_hit) tmo_q <= tmo_q + 1'b1;
               if (is_rx_q) begin
                  if (network_ack_in) begin
                     ack_q   <= 1'b1;
                     state_q <= ST_DONE;
                  end else if (tmo_hit) begin
                     miss_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end
               // Parity beats data-ready; a timeout only counts if nothing terminated this cycle.
               end else if (parity_error_in || (tmo_hit && !network_data_ready_in)) begin
                  if (retry_q < RETRY_MAX) begin
                     retry_q    <= retry_q + 1'b1;
                     op_valid_q <= 1'b1;
                     opcode_q   <= OP_TXE;
                     state_q    <= ST_ISSUE;
                  end else begin
                     fail_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end
               end else if (network_data_ready_in) begin
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE:  state_q <= ST_IDLE;
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

   assign host_tx_grant = grant[0];
   assign net_rx_grant  = grant[1];
   assign opcode_out    = opcode_q;
   assign op_valid_out  = op_valid_q;
   assign tx_data_out   = tx_data_q;
   assign tx_tag_out    = tx_tag_q;
   assign ndt_out       = ndt_q;
   assign host_done_out = done_q;
   assign host_fail_out = fail_q;
   assign net_ack_out   = ack_q;
   assign net_miss_out  = miss_q;
   assign busy_out      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_asp_op_scheduler.sv
// Directed bench for asp_op_scheduler: grants, issue timing, retries, timeouts, reset.
import asp_pkg::*;

module tb_asp_op_scheduler;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        host_tx_req, host_tx_grant, net_rx_req, net_rx_grant;
   logic [31:0] host_tx_data, tx_data_out;
   logic [7:0]  host_tx_tag, tx_tag_out;
   logic [39:0] net_rx_ndt, ndt_out;
   logic [1:0]  opcode_out;
   logic        op_valid_out, parity_error_in, network_data_ready_in, network_ack_in;
   logic        host_done_out, host_fail_out, net_ack_out, net_miss_out, busy_out;

   int tests = 0, fails = 0;
   int n_txe = 0, n_rxa = 0, n_done = 0, n_fail = 0, n_ack = 0, n_miss = 0;
   int s_txe, s_done, s_fail, s_ack, lat;

   always #5 clk = ~clk;

   asp_op_scheduler dut (
      .clk(clk), .reset_n(reset_n),
      .host_tx_req(host_tx_req), .host_tx_data(host_tx_data), .host_tx_tag(host_tx_tag),
      .host_tx_grant(host_tx_grant),
      .net_rx_req(net_rx_req), .net_rx_ndt(net_rx_ndt), .net_rx_grant(net_rx_grant),
      .opcode_out(opcode_out), .op_valid_out(op_valid_out),
      .tx_data_out(tx_data_out), .tx_tag_out(tx_tag_out), .ndt_out(ndt_out),
      .parity_error_in(parity_error_in), .network_data_ready_in(network_data_ready_in),
      .network_ack_in(network_ack_in),
      .host_done_out(host_done_out), .host_fail_out(host_fail_out),
      .net_ack_out(net_ack_out), .net_miss_out(net_miss_out), .busy_out(busy_out)
   );

   always @(negedge clk) begin
      if (op_valid_out && opcode_out == OP_TXE) n_txe++;
      if (op_valid_out && opcode_out == OP_RXA) n_rxa++;
      if (host_done_out) n_done++;
      if (host_fail_out) n_fail++;
      if (net_ack_out)   n_ack++;
      if (net_miss_out)  n_miss++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; host_tx_req = 1'b1; net_rx_req = 1'b0;
      host_tx_data = '0; host_tx_tag = '0; net_rx_ndt = '0;
      parity_error_in = 1'b0; network_data_ready_in = 1'b0; network_ack_in = 1'b0;
      #3;
      check("rst_grant", host_tx_grant, 1'b0);
      check("rst_busy", busy_out, 1'b0);
      check("rst_opcode", opcode_out, OP_NOP);
      check("rst_opvalid", op_valid_out, 1'b0);
      host_tx_req = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Host-only TXE, data ready 3 cycles after issue
      s_txe = n_txe; s_done = n_done;
      host_tx_req = 1'b1; host_tx_data = 32'hDEADBEEF; host_tx_tag = 8'h5A;
      #1;
      check("t1_grant", host_tx_grant, 1'b1);
      check("t1_net_grant", net_rx_grant, 1'b0);
      @(negedge clk);
      check("t1_opvalid", op_valid_out, 1'b1);
      check("t1_opcode", opcode_out, OP_TXE);
      check("t1_data", tx_data_out, 32'hDEADBEEF);
      check("t1_tag", tx_tag_out, 8'h5A);
      check("t1_busy", busy_out, 1'b1);
      host_tx_req = 1'b0; host_tx_data = '0; network_data_ready_in = 1'b1;
      @(negedge clk);
      network_data_ready_in = 1'b0;
      check("t1_nop", opcode_out, OP_NOP);
      check("t1_ready_ignored", host_done_out, 1'b0);
      @(negedge clk);
      @(negedge clk);
      network_data_ready_in = 1'b1;
      @(negedge clk);
      check("t1_done", host_done_out, 1'b1);
      check("t1_nofail", host_fail_out, 1'b0);
      network_data_ready_in = 1'b0;
      @(negedge clk);
      check("t1_done_pulse", host_done_out, 1'b0);
      check("t1_idle_busy", busy_out, 1'b0);
      check("t1_issues", n_txe - s_txe, 1);
      check("t1_donecnt", n_done - s_done, 1);

      // Simultaneous requests twice: host first, then network
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      host_tx_req = 1'b1; host_tx_data = 32'h11111111; host_tx_tag = 8'h22;
      net_rx_req = 1'b1; net_rx_ndt = 40'hA50BADF00D;
      #1;
      check("t2_host_first", host_tx_grant, 1'b1);
      check("t2_net_wait", net_rx_grant, 1'b0);
      @(negedge clk);
      check("t2_txe", opcode_out, OP_TXE);
      host_tx_req = 1'b0;
      @(negedge clk);
      network_data_ready_in = 1'b1;
      @(negedge clk);
      check("t2_host_done", host_done_out, 1'b1);
      check("t2_no_grant_done", net_rx_grant, 1'b0);
      network_data_ready_in = 1'b0;
      @(negedge clk);
      host_tx_req = 1'b1;
      #1;
      check("t2_net_second", net_rx_grant, 1'b1);
      check("t2_host_held", host_tx_grant, 1'b0);
      @(negedge clk);
      check("t2_rxa", opcode_out, OP_RXA);
      check("t2_ndt", ndt_out, 40'hA50BADF00D);
      check("t2_txdata_hold", tx_data_out, 32'h11111111);
      host_tx_req = 1'b0; net_rx_req = 1'b0;
      @(negedge clk);
      network_ack_in = 1'b1;
      @(negedge clk);
      check("t2_net_ack", net_ack_out, 1'b1);
      network_ack_in = 1'b0;
      @(negedge clk);

      // Parity error on every attempt: 4 issues then fail
      s_txe = n_txe; s_done = n_done; s_fail = n_fail;
      host_tx_req = 1'b1; host_tx_data = 32'h33333333;
      @(negedge clk);
      host_tx_req = 1'b0; parity_error_in = 1'b1;
      lat = 0;
      for (int i = 1; i <= 40 && lat == 0; i++) begin
         @(negedge clk);
         if (host_fail_out) lat = i;
      end
      parity_error_in = 1'b0;
      check("t3_fail_latency", lat, 8);
      repeat (2) @(negedge clk);
      check("t3_issues", n_txe - s_txe, 4);
      check("t3_failcnt", n_fail - s_fail, 1);
      check("t3_no_done", n_done - s_done, 0);

      // RXA with no ack: miss after 16 WAIT cycles
      s_ack = n_ack;
      net_rx_req = 1'b1; net_rx_ndt = 40'h0102030405;
      @(negedge clk);
      net_rx_req = 1'b0;
      lat = 0;
      for (int i = 1; i <= 30 && lat == 0; i++) begin
         @(negedge clk);
         if (net_miss_out) lat = i;
      end
      check("t4_miss_latency", lat, 17);
      @(negedge clk);
      check("t4_no_ack", n_ack - s_ack, 0);

      // TXE timeouts consume retries
      s_txe = n_txe; s_done = n_done;
      host_tx_req = 1'b1;
      @(negedge clk);
      host_tx_req = 1'b0;
      lat = 0;
      for (int i = 1; i <= 100 && lat == 0; i++) begin
         @(negedge clk);
         if (host_fail_out) lat = i;
      end
      check("t4_tmo_fail_latency", lat, 68);
      repeat (2) @(negedge clk);
      check("t4_tmo_issues", n_txe - s_txe, 4);
      check("t4_tmo_no_done", n_done - s_done, 0);

      // Parity + ready together retries; reset during WAIT clears everything
      s_done = n_done; s_fail = n_fail;
      host_tx_req = 1'b1; host_tx_data = 32'hCAFE0001; host_tx_tag = 8'h77;
      @(negedge clk);
      host_tx_req = 1'b0;
      @(negedge clk);
      parity_error_in = 1'b1; network_data_ready_in = 1'b1;
      @(negedge clk);
      check("t5_retry_valid", op_valid_out, 1'b1);
      check("t5_retry_op", opcode_out, OP_TXE);
      check("t5_no_done", host_done_out, 1'b0);
      parity_error_in = 1'b0; network_data_ready_in = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("t5_rst_busy", busy_out, 1'b0);
      check("t5_rst_data", tx_data_out, 32'h0);
      check("t5_rst_tag", tx_tag_out, 8'h0);
      check("t5_rst_ndt", ndt_out, 40'h0);
      check("t5_rst_opcode", opcode_out, OP_NOP);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      check("t5_no_pulse_done", n_done - s_done, 0);
      check("t5_no_pulse_fail", n_fail - s_fail, 0);
      check("t5_idle", busy_out, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
